// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer and its word adder.
package wide_add_sequencer_pkg;

  // Width of the shared adder datapath and its log2 (word offset shift).
  localparam int WORD_W    = 16;
  localparam int WORD_LOG2 = 4;

  // Encoding of the sub input that selects subtraction.
  localparam logic OP_SUB = 1'b1;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// Single WORD_W-bit ripple-style adder shared by every word of a wide operation.
module fulladder
  import wide_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in,
  output logic [WORD_W-1:0] s,
  output logic              c_out
);

  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, c_in};

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide (WORD_W*WORDS-bit) add/subtract built by walking one fulladder across the
// operand words, least-significant word first, with the carry held between words.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic                      c_in,
  input  logic [WORD_W*WORDS-1:0]   op_a,
  input  logic [WORD_W*WORDS-1:0]   op_b,
  output logic                      busy,
  output logic                      done,
  output logic [WORD_W*WORDS-1:0]   result,
  output logic                      c_out,
  output logic                      overflow
);

  localparam int DATA_W = WORD_W * WORDS;
  localparam int IDX_W  = $clog2(WORDS);
  localparam int SEL_W  = IDX_W + WORD_LOG2;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              last_word;

  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;   // already inverted for subtract
  logic              carry;
  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  base;     // bit offset of the current word

  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic [WORD_W-1:0] add_s;
  logic              add_cout;

  assign base      = {idx, {WORD_LOG2{1'b0}}};
  assign last_word = (idx == IDX_W'(WORDS - 1));
  assign add_a     = op_a_q[base +: WORD_W];
  assign add_b     = op_b_q[base +: WORD_W];

  fulladder u_adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry),
    .s     (add_s),
    .c_out (add_cout)
  );

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
    end
  end

  // Next-state decode; start is only honoured while idle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN:     if (last_word) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on accept; B is stored pre-inverted for subtract.
  always_ff @(posedge clk) begin
    // NOTE: operand registers carry no reset; they are always loaded on accept
    // before any word of them is consumed.
    if (accept) begin
      op_a_q <= op_a;
      op_b_q <= (sub == OP_SUB) ? ~op_b : op_b;
    end
  end

  // Per-word datapath: write one result word and advance the carry each RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      carry <= (sub == OP_SUB) ? 1'b1 : c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      result[base +: WORD_W] <= add_s;
      carry                  <= add_cout;
      idx                    <= idx + 1'b1;
      if (last_word) begin
        c_out    <= add_cout;
        overflow <= (op_a_q[DATA_W-1] == op_b_q[DATA_W-1]) &&
                    (add_s[WORD_W-1] != op_a_q[DATA_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed vectors and random ops on a 4-word and a
// 2-word instance, with a scoreboard that checks every done pulse.
module tb_wide_add_sequencer;

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    bit          spam;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sub, c_in;
  logic        start4, start2;
  logic [63:0] a4, b4, result4;
  logic [31:0] a2, b2, result2;
  logic        busy4, done4, c_out4, ovf4;
  logic        busy2, done2, c_out2, ovf2;
  logic        done4_d = 1'b0;
  logic        done2_d = 1'b0;

  int   errors = 0;
  int   checks = 0;
  exp_t q4[$];
  exp_t q2[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  wide_add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .c_in(c_in),
    .op_a(a4), .op_b(b4), .busy(busy4), .done(done4),
    .result(result4), .c_out(c_out4), .overflow(ovf4)
  );

  wide_add_sequencer #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub), .c_in(c_in),
    .op_a(a2), .op_b(b2), .busy(busy2), .done(done2),
    .result(result2), .c_out(c_out2), .overflow(ovf2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Full-width reference: plain modular add of A, B (or ~B) and the carry-in.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic ci, input int n);
    exp_t        r;
    int          w;
    logic [64:0] mask, aa, bb, sum;
    w    = 16 * n;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    sum  = aa + bb + {64'd0, (s ? 1'b1 : ci)};
    r.res  = sum[63:0] & mask[63:0];
    r.cout = sum[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      check("done4_width", {63'd0, done4_d}, 64'd0);
      check("done4_expected", {63'd0, (q4.size() != 0)}, 64'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("result4", result4, e.res);
        check("c_out4", {63'd0, c_out4}, {63'd0, e.cout});
        check("ovf4", {63'd0, ovf4}, {63'd0, e.ovf});
      end
    end
    if (done2) begin
      check("done2_width", {63'd0, done2_d}, 64'd0);
      check("done2_expected", {63'd0, (q2.size() != 0)}, 64'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("result2", {32'd0, result2}, e.res);
        check("c_out2", {63'd0, c_out2}, {63'd0, e.cout});
        check("ovf2", {63'd0, ovf2}, {63'd0, e.ovf});
      end
    end
    done4_d = done4;
    done2_d = done2;
  end

  // One operation on the n-word instance with cycle-exact busy/done checks;
  // spam re-asserts start with fresh operands while the op is in flight.
  task automatic run_op(input int n, input logic s, input logic ci,
                        input logic [63:0] a, input logic [63:0] b,
                        input exp_t e, input bit spam);
    logic [1:0] bd;
    sub  = s;
    c_in = ci;
    if (n == 4) begin
      a4 = a; b4 = b; q4.push_back(e); start4 = 1'b1;
    end else begin
      a2 = a[31:0]; b2 = b[31:0]; q2.push_back(e); start2 = 1'b1;
    end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start2 = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      bd = (n == 4) ? {busy4, done4} : {busy2, done2};
      check($sformatf("busy_done_w%0d_c%0d", n, c), {62'd0, bd}, (c <= n) ? 64'h2 : 64'h1);
      if (spam && c >= 2) begin
        sub = 1'($urandom_range(0, 1));
        if (n == 4) begin
          start4 = 1'b1; a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom};
        end else begin
          start2 = 1'b1; a2 = $urandom; b2 = $urandom;
        end
      end
    end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    bd = (n == 4) ? {busy4, done4} : {busy2, done2};
    check($sformatf("idle_after_w%0d", n), {62'd0, bd}, 64'h0);
  endtask

  initial begin
    exp_t        e;
    logic [63:0] ra, rb;
    logic        rs, rc;

    vecs[0] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 64'h0, 64'h0, 64'h1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start4 = 1'b0; start2 = 1'b0; sub = 1'b0; c_in = 1'b0;
    a4 = '0; b4 = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy4}, 64'd0);
    check("rst_done", {63'd0, done4}, 64'd0);
    check("rst_result", result4, 64'd0);
    check("rst_c_out", {63'd0, c_out4}, 64'd0);
    check("rst_ovf", {63'd0, ovf4}, 64'd0);
    check("rst_result2", {32'd0, result2}, 64'd0);
    // Start coincident with reset must be dropped.
    start4 = 1'b1;
    @(negedge clk);
    check("rst_beats_start", {63'd0, busy4}, 64'd0);
    start4 = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    // Directed table on the 4-word instance.
    for (int i = 0; i < 7; i++) begin
      e.res  = vecs[i].res;
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      run_op(4, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, e, vecs[i].spam);
    end

    // Reset in cycle 3 of a RUN aborts the op with no done pulse.
    sub = 1'b0; c_in = 1'b0;
    a4 = 64'h1111_2222_3333_4444; b4 = 64'h1; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {63'd0, busy4}, 64'd0);
    check("abort_done", {63'd0, done4}, 64'd0);
    check("abort_result", result4, 64'd0);
    check("abort_c_out", {63'd0, c_out4}, 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_still_idle", {62'd0, busy4, done4}, 64'd0);
    e.res = 64'h0; e.cout = 1'b1; e.ovf = 1'b0;
    run_op(4, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, e, 1'b0);

    // Random ops on both widths against the reference model.
    for (int n = 2; n <= 4; n += 2) begin
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom};
        rb = (i % 4 == 0) ? ~ra : {$urandom, $urandom};
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        run_op(n, rs, rc, ra, rb, model(ra, rb, rs, rc, n), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("q4_drained", 64'(q4.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
